// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the two-port data memory arbiter: client request/response
// signals for both ports plus the shared memory-side strobes and data.
interface data_mem_arbiter_if;
    localparam int unsigned DATA_W = 32;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output rdata0, rdata1, ack0, ack1,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    // Requesting clients.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  rdata0, rdata1, ack0, ack1
    );

    // Memory model.
    modport mem (
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// One-cycle grants, registered acks/read data and per-port completion counters.
module data_mem_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]   o_cnt0,
    output logic [CNT_W-1:0]   o_cnt1,
    output logic               o_busy
);
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_grant;
    logic              r_busy;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic [DATA_W-1:0] w_mem_address;
    logic [DATA_W-1:0] w_mem_write_data;
    logic              w_mem_read;
    logic              w_mem_write;

    // State register; last_grant follows every grant entry so ties alternate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_next_state == S_GRANT0) begin
                r_last_grant <= 1'b0;
            end else if (w_next_state == S_GRANT1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // Next state and memory-side strobes for the granted port.
    always_comb begin
        w_next_state     = r_state;
        w_mem_address    = '0;
        w_mem_write_data = '0;
        w_mem_read       = 1'b0;
        w_mem_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_next_state = r_last_grant ? S_GRANT0 : S_GRANT1;
                end else if (bus.req0) begin
                    w_next_state = S_GRANT0;
                end else if (bus.req1) begin
                    w_next_state = S_GRANT1;
                end
            end
            S_GRANT0: begin
                w_next_state     = bus.req1 ? S_GRANT1 : S_IDLE;
                w_mem_address    = bus.addr0;
                w_mem_write_data = bus.wdata0;
                w_mem_write      = bus.we0;
                w_mem_read       = ~bus.we0;
            end
            S_GRANT1: begin
                w_next_state     = bus.req0 ? S_GRANT0 : S_IDLE;
                w_mem_address    = bus.addr1;
                w_mem_write_data = bus.wdata1;
                w_mem_write      = bus.we1;
                w_mem_read       = ~bus.we1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Completion side: ack pulse, read capture and counters at the end of a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt0   <= '0;
            r_cnt1   <= '0;
        end else begin
            r_ack0 <= (r_state == S_GRANT0);
            r_ack1 <= (r_state == S_GRANT1);
            if (r_state == S_GRANT0) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
                if (!bus.we0) begin
                    r_rdata0 <= bus.mem_read_data;
                end
            end
            if (r_state == S_GRANT1) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
                if (!bus.we1) begin
                    r_rdata1 <= bus.mem_read_data;
                end
            end
        end
    end

    assign bus.mem_address    = w_mem_address;
    assign bus.mem_write_data = w_mem_write_data;
    assign bus.mem_read       = w_mem_read;
    assign bus.mem_write      = w_mem_write;
    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.rdata0         = r_rdata0;
    assign bus.rdata1         = r_rdata1;
    assign o_cnt0             = r_cnt0;
    assign o_cnt1             = r_cnt1;
    assign o_busy             = r_busy;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word memory model;
// counters are built 2 bits wide so the wrap is reachable quickly.
module tb_data_mem_arbiter;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic             busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic mem_clear;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .o_cnt0 (cnt0),
        .o_cnt1 (cnt1),
        .o_busy (busy)
    );

    // Word memory: never reset, writes commit on the clock edge.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_address[5:0]] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address[5:0]] : '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0 = 1'b0;  bus.we1 = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    // Strobes must be mutually exclusive at all times.
    always @(negedge clk) begin
        if (mon_en) check_eq("mutex", 32'(bus.mem_read & bus.mem_write), 32'd0);
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        mem_clear = 1'b1;
        tick();
        mem_clear = 1'b0;
        tick();
        check_eq("rst_ack0", 32'(bus.ack0), 32'd0);
        check_eq("rst_ack1", 32'(bus.ack1), 32'd0);
        check_eq("rst_rdata0", bus.rdata0, 32'd0);
        check_eq("rst_rdata1", bus.rdata1, 32'd0);
        check_eq("rst_cnt0", 32'(cnt0), 32'd0);
        check_eq("rst_cnt1", 32'(cnt1), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_wr", 32'(bus.mem_write), 32'd0);
        check_eq("rst_mem_rd", 32'(bus.mem_read), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single write from port 0.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd2; bus.wdata0 = 32'h0000_FFFF;
        check_eq("w_idle_wr", 32'(bus.mem_write), 32'd0);
        tick();
        check_eq("w_busy", 32'(busy), 32'd1);
        check_eq("w_mem_wr", 32'(bus.mem_write), 32'd1);
        check_eq("w_mem_rd", 32'(bus.mem_read), 32'd0);
        check_eq("w_addr", bus.mem_address, 32'd2);
        check_eq("w_wdata", bus.mem_write_data, 32'h0000_FFFF);
        check_eq("w_ack_early", 32'(bus.ack0), 32'd0);
        tick();
        check_eq("w_ack0", 32'(bus.ack0), 32'd1);
        check_eq("w_cnt0", 32'(cnt0), 32'd1);
        check_eq("w_idle_busy", 32'(busy), 32'd0);
        bus.req0 = 1'b0;
        tick();
        check_eq("w_ack0_pulse", 32'(bus.ack0), 32'd0);

        // Readback through port 1.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd2;
        tick();
        check_eq("rb_mem_rd", 32'(bus.mem_read), 32'd1);
        check_eq("rb_mem_wr", 32'(bus.mem_write), 32'd0);
        check_eq("rb_addr", bus.mem_address, 32'd2);
        tick();
        check_eq("rb_ack1", 32'(bus.ack1), 32'd1);
        check_eq("rb_rdata1", bus.rdata1, 32'h0000_FFFF);
        check_eq("rb_rdata0", bus.rdata0, 32'd0);
        check_eq("rb_cnt1", 32'(cnt1), 32'd1);
        bus.req1 = 1'b0;
        tick();

        // Tie straight after reset: port 0 first, then strict alternation.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd5;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd6;
        tick();
        check_eq("tie_g0_addr", bus.mem_address, 32'd5);
        check_eq("tie_g0_busy", 32'(busy), 32'd1);
        tick();
        check_eq("tie_g1_addr", bus.mem_address, 32'd6);
        check_eq("tie_g1_ack0", 32'(bus.ack0), 32'd1);
        check_eq("tie_g1_ack1", 32'(bus.ack1), 32'd0);
        tick();
        check_eq("tie_g0b_addr", bus.mem_address, 32'd5);
        check_eq("tie_g0b_ack1", 32'(bus.ack1), 32'd1);
        check_eq("tie_g0b_ack0", 32'(bus.ack0), 32'd0);
        check_eq("tie_cnt0_a", 32'(cnt0), 32'd1);
        check_eq("tie_cnt1_a", 32'(cnt1), 32'd1);
        tick();
        check_eq("tie_g1b_addr", bus.mem_address, 32'd6);
        check_eq("tie_g1b_ack0", 32'(bus.ack0), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        check_eq("tie_end_busy", 32'(busy), 32'd0);
        check_eq("tie_end_ack1", 32'(bus.ack1), 32'd1);
        check_eq("tie_cnt0_b", 32'(cnt0), 32'd2);
        check_eq("tie_cnt1_b", 32'(cnt1), 32'd2);
        check_eq("tie_rdata0", bus.rdata0, 32'hA000_0005);
        check_eq("tie_rdata1", bus.rdata1, 32'hA000_0006);
        tick();

        // Reset during a port-1 write: no ack, but the write still lands.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd11; bus.wdata1 = 32'hFFFF_0000;
        tick();
        check_eq("rm_mem_wr", 32'(bus.mem_write), 32'd1);
        check_eq("rm_addr", bus.mem_address, 32'd11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req1 = 1'b0;
        check_eq("rm_ack1", 32'(bus.ack1), 32'd0);
        check_eq("rm_cnt1", 32'(cnt1), 32'd0);
        check_eq("rm_busy", 32'(busy), 32'd0);
        check_eq("rm_mem_idle", 32'(bus.mem_write), 32'd0);
        tick();
        check_eq("rm_no_late_ack", 32'(bus.ack1), 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd11;
        tick();
        check_eq("rm_rd", 32'(bus.mem_read), 32'd1);
        tick();
        check_eq("rm_ack0", 32'(bus.ack0), 32'd1);
        check_eq("rm_rdata0", bus.rdata0, 32'hFFFF_0000);
        bus.req0 = 1'b0;
        tick();

        // Counter wrap on back-to-back port-0 reads.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd20;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("wrap_rd", 32'(bus.mem_read), 32'd1);
            check_eq("wrap_addr", bus.mem_address, 32'(20 + k));
            tick();
            check_eq("wrap_ack0", 32'(bus.ack0), 32'd1);
            check_eq("wrap_cnt0", 32'(cnt0), 32'((k + 1) % 4));
            check_eq("wrap_rdata0", bus.rdata0, 32'hA000_0000 | 32'(20 + k));
            bus.addr0 = 32'(21 + k);
            if (k == 4) bus.req0 = 1'b0;
        end
        tick();
        check_eq("wrap_end_ack0", 32'(bus.ack0), 32'd0);
        check_eq("wrap_end_busy", 32'(busy), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
